apb_gpio_ctrl: RTL and testbench

//  Parametrised APB3 GPIO controller. Successor to the fixed 8-pin GPIO: configurable pin count,

---
 rtl/gpio_pkg.sv | 24 ++
 rtl/gpio_sync.sv | 25 ++
 rtl/apb_gpio_ctrl.sv | 113 +++++++++++
 tb/tb_apb_gpio_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared register map and address decode helpers for the APB GPIO controller.
// Offsets are byte addresses within the 64-byte window selected by PADDR[5:2].
package gpio_pkg;

  localparam logic [5:0] GPIO_EN   = 6'h00;
  localparam logic [5:0] GPIO_DIR  = 6'h04;
  localparam logic [5:0] GPIO_SET  = 6'h08;
  localparam logic [5:0] GPIO_CLR  = 6'h0C;
  localparam logic [5:0] GPIO_IN   = 6'h10;
  localparam logic [5:0] GPIO_OUT  = 6'h14;
  localparam logic [5:0] GPIO_RISE = 6'h18;
  localparam logic [5:0] GPIO_FALL = 6'h1C;
  localparam logic [5:0] GPIO_STAT = 6'h20;

  // Word index back to a byte offset so case labels can use the offsets directly.
  function automatic logic [5:0] gpio_offset(input logic [3:0] word);
    return {word, 2'b00};
  endfunction

  function automatic logic gpio_mapped(input logic [5:0] off);
    return off <= GPIO_STAT;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs; all bits resampled in parallel.
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/apb_gpio_ctrl.sv
// APB3 GPIO controller: zero-wait-state register file, synchronised masked inputs,
// per-pin rising/falling edge capture into sticky status and a level interrupt.
module apb_gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int NPINS       = 8,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NPINS-1:0]  gpio_i,
  output logic [NPINS-1:0]  gpio_o,
  output logic [NPINS-1:0]  gpio_oe,
  output logic              irq
);

  logic [NPINS-1:0] r_en, r_dir, r_out, r_rise, r_fall, r_stat, r_prev;
  logic [NPINS-1:0] w_sync, w_in, w_ev, w_wdata, w_stat_clr, w_rd;
  logic [5:0]       w_off;
  logic             w_access, w_err, w_wr;
  logic             w_unused;

  assign w_off    = gpio_offset(PADDR[5:2]);
  assign w_access = PSEL & PENABLE;
  assign w_err    = w_access & (~gpio_mapped(w_off) | (PWRITE & (w_off == GPIO_IN)));
  assign w_wr     = w_access & PWRITE & ~w_err;
  assign w_wdata  = PWDATA[NPINS-1:0];
  assign w_unused = ^{PADDR, PWDATA};

  gpio_sync #(
    .WIDTH  (NPINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_d     (gpio_i),
    .o_q     (w_sync)
  );

  // Masking before edge detect means EN/DIR changes can themselves raise events.
  assign w_in       = w_sync & r_en & ~r_dir;
  assign w_ev       = (r_rise & w_in & ~r_prev) | (r_fall & ~w_in & r_prev);
  assign w_stat_clr = (w_wr && (w_off == GPIO_STAT)) ? w_wdata : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_en   <= '0;
      r_dir  <= '0;
      r_out  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_stat <= '0;
      r_prev <= '0;
    end else begin
      r_prev <= w_in;
      // OR-ing events after the clear lets a same-cycle event win over W1C.
      r_stat <= (r_stat & ~w_stat_clr) | w_ev;
      if (w_wr) begin
        case (w_off)
          GPIO_EN:   r_en   <= w_wdata;
          GPIO_DIR:  r_dir  <= w_wdata;
          GPIO_SET:  r_out  <= r_out | w_wdata;
          GPIO_CLR:  r_out  <= r_out & ~w_wdata;
          GPIO_OUT:  r_out  <= w_wdata;
          GPIO_RISE: r_rise <= w_wdata;
          GPIO_FALL: r_fall <= w_wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    if (PSEL && !PWRITE) begin
      case (w_off)
        GPIO_EN:   w_rd = r_en;
        GPIO_DIR:  w_rd = r_dir;
        GPIO_IN:   w_rd = w_in;
        GPIO_OUT:  w_rd = r_out;
        GPIO_RISE: w_rd = r_rise;
        GPIO_FALL: w_rd = r_fall;
        GPIO_STAT: w_rd = r_stat;
        default:   w_rd = '0;
      endcase
    end
  end

  generate
    if (NPINS < DATA_W) begin : g_rd_pad
      assign PRDATA = {{(DATA_W-NPINS){1'b0}}, w_rd};
    end else begin : g_rd_full
      assign PRDATA = w_rd;
    end
  endgenerate

  assign PREADY  = 1'b1;
  assign PSLVERR = w_err;
  assign gpio_oe = r_en & r_dir;
  assign gpio_o  = r_out & r_en & r_dir;
  assign irq     = |r_stat;

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Scoreboard bench for apb_gpio_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops one per APB access phase and compares bus and pad outputs.
module tb_apb_gpio_ctrl;

  localparam logic [7:0] A_EN = 8'h00, A_DIR = 8'h04, A_SET = 8'h08, A_CLR = 8'h0C;
  localparam logic [7:0] A_IN = 8'h10, A_OUT = 8'h14, A_RISE = 8'h18, A_FALL = 8'h1C;
  localparam logic [7:0] A_STAT = 8'h20;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL8 = 1'b0, PSEL4 = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] prdata8, prdata4;
  logic        pready8, pready4, slverr8, slverr4;
  logic [7:0]  gpio_i8 = '0, gpio_o8, gpio_oe8;
  logic [3:0]  gpio_i4 = '0, gpio_o4, gpio_oe4;
  logic        irq8, irq4;

  always #5 PCLK = ~PCLK;

  apb_gpio_ctrl #(.NPINS(8), .ADDR_W(8), .DATA_W(32), .SYNC_STAGES(2)) u_dut8 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL8), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(slverr8),
    .gpio_i(gpio_i8), .gpio_o(gpio_o8), .gpio_oe(gpio_oe8), .irq(irq8)
  );

  apb_gpio_ctrl #(.NPINS(4), .ADDR_W(8), .DATA_W(32), .SYNC_STAGES(2)) u_dut4 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL4), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata4), .PREADY(pready4), .PSLVERR(slverr4),
    .gpio_i(gpio_i4), .gpio_o(gpio_o4), .gpio_oe(gpio_oe4), .irq(irq4)
  );

  typedef struct {
    string       name;
    bit          sel4;
    logic [31:0] rd;
    logic        err;
    bit          chk_pin;
    logic [7:0]  oe;
    logic [7:0]  o;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s.%s actual=0x%08h expected=0x%08h", nm, fld, act, expv);
    end
  endtask

  // Monitor: every access phase must match the oldest queued expectation.
  always @(negedge PCLK) begin
    if (PENABLE && (PSEL8 || PSEL4)) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_access addr=0x%02h actual=access expected=none", PADDR);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.sel4) begin
          chk(mon_e.name, "prdata", prdata4, mon_e.rd);
          chk(mon_e.name, "pslverr", {31'b0, slverr4}, {31'b0, mon_e.err});
          chk(mon_e.name, "pready", {31'b0, pready4}, 32'd1);
          if (mon_e.chk_pin) begin
            chk(mon_e.name, "gpio_oe", {28'b0, gpio_oe4}, {24'b0, mon_e.oe});
            chk(mon_e.name, "gpio_o", {28'b0, gpio_o4}, {24'b0, mon_e.o});
            chk(mon_e.name, "irq", {31'b0, irq4}, {31'b0, mon_e.irq});
          end
        end else begin
          chk(mon_e.name, "prdata", prdata8, mon_e.rd);
          chk(mon_e.name, "pslverr", {31'b0, slverr8}, {31'b0, mon_e.err});
          chk(mon_e.name, "pready", {31'b0, pready8}, 32'd1);
          if (mon_e.chk_pin) begin
            chk(mon_e.name, "gpio_oe", {24'b0, gpio_oe8}, {24'b0, mon_e.oe});
            chk(mon_e.name, "gpio_o", {24'b0, gpio_o8}, {24'b0, mon_e.o});
            chk(mon_e.name, "irq", {31'b0, irq8}, {31'b0, mon_e.irq});
          end
        end
        $display("txn %-14s addr=0x%02h wr=%0d prdata8=0x%08h prdata4=0x%08h err8=%0d err4=%0d irq8=%0d",
                 mon_e.name, PADDR, PWRITE, prdata8, prdata4, slverr8, slverr4, irq8);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // One APB transfer; called and returns 1 time unit after a rising edge.
  task automatic xfer(input bit sel4, input bit wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_rd, input logic exp_err, input bit chk_pin,
                      input logic [7:0] exp_oe, input logic [7:0] exp_o, input logic exp_irq,
                      input string name);
    exp_t e;
    e.name = name; e.sel4 = sel4; e.rd = exp_rd; e.err = exp_err;
    e.chk_pin = chk_pin; e.oe = exp_oe; e.o = exp_o; e.irq = exp_irq;
    sb_q.push_back(e);
    PSEL8 = ~sel4; PSEL4 = sel4; PWRITE = wr; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL8 = 1'b0; PSEL4 = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr8(input logic [7:0] a, input logic [31:0] d, input logic err, input string nm);
    xfer(1'b0, 1'b1, a, d, 32'h0, err, 1'b0, 8'h0, 8'h0, 1'b0, nm);
  endtask
  task automatic rd8(input logic [7:0] a, input logic [31:0] expv, input logic err, input string nm);
    xfer(1'b0, 1'b0, a, 32'h0, expv, err, 1'b0, 8'h0, 8'h0, 1'b0, nm);
  endtask
  task automatic wrp(input logic [7:0] a, input logic [31:0] d, input logic [7:0] oe,
                     input logic [7:0] o, input logic q, input string nm);
    xfer(1'b0, 1'b1, a, d, 32'h0, 1'b0, 1'b1, oe, o, q, nm);
  endtask
  task automatic rdp(input logic [7:0] a, input logic [31:0] expv, input logic [7:0] oe,
                     input logic [7:0] o, input logic q, input string nm);
    xfer(1'b0, 1'b0, a, 32'h0, expv, 1'b0, 1'b1, oe, o, q, nm);
  endtask

  initial begin
    exp_t e;
    idle(3);
    PRESETn = 1'b1;
    idle(1);

    // T1: state written, then reset lands mid-write of EN and wipes everything
    wrp(A_DIR, 32'h0F, 8'h00, 8'h00, 1'b0, "t1_dir");
    wrp(A_OUT, 32'hFF, 8'h00, 8'h00, 1'b0, "t1_out");
    wr8(A_RISE, 32'h01, 1'b0, "t1_rise");
    e.name = "t1_rst_abort"; e.sel4 = 1'b0; e.rd = 32'h0; e.err = 1'b0;
    e.chk_pin = 1'b1; e.oe = 8'h0; e.o = 8'h0; e.irq = 1'b0;
    sb_q.push_back(e);
    PSEL8 = 1'b1; PWRITE = 1'b1; PADDR = A_EN; PWDATA = 32'hFF; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PSEL8 = 1'b0; PENABLE = 1'b0;
    idle(2);
    PRESETn = 1'b1;
    rdp(A_EN,   32'h00, 8'h00, 8'h00, 1'b0, "t1_en_rd");
    rd8(A_DIR,  32'h00, 1'b0, "t1_dir_rd");
    rd8(A_OUT,  32'h00, 1'b0, "t1_out_rd");
    rd8(A_RISE, 32'h00, 1'b0, "t1_rise_rd");

    // T2: output path
    wr8(A_EN,  32'h0F, 1'b0, "t2_en");
    wr8(A_DIR, 32'h05, 1'b0, "t2_dir");
    wr8(A_SET, 32'hFF, 1'b0, "t2_set");
    rdp(A_OUT, 32'hFF, 8'h05, 8'h05, 1'b0, "t2_out_set");
    rd8(A_SET, 32'h00, 1'b0, "t2_set_rd");
    wr8(A_CLR, 32'h01, 1'b0, "t2_clr");
    rdp(A_OUT, 32'hFE, 8'h05, 8'h04, 1'b0, "t2_out_clr");
    rd8(A_CLR, 32'h00, 1'b0, "t2_clr_rd");

    // T3: input latency is exactly two edges
    wr8(A_EN,  32'hFF, 1'b0, "t3_en");
    wr8(A_DIR, 32'h00, 1'b0, "t3_dir");
    gpio_i8 = 8'hA5;
    rd8(A_IN, 32'h00, 1'b0, "t3_in_1edge");
    rdp(A_IN, 32'hA5, 8'h00, 8'h00, 1'b0, "t3_in_a5");
    gpio_i8 = 8'h5A;
    idle(1);
    rd8(A_IN, 32'h5A, 1'b0, "t3_in_2edge");

    // T4: edge interrupts and W1C
    gpio_i8 = 8'h80;
    wr8(A_RISE, 32'h01, 1'b0, "t4_rise");
    wr8(A_FALL, 32'h80, 1'b0, "t4_fall");
    rdp(A_STAT, 32'h00, 8'h00, 8'h00, 1'b0, "t4_stat_idle");
    gpio_i8 = 8'h81;
    idle(1);
    rdp(A_STAT, 32'h00, 8'h00, 8'h00, 1'b0, "t4_stat_e2");
    rdp(A_STAT, 32'h01, 8'h00, 8'h00, 1'b1, "t4_stat_p0");
    gpio_i8 = 8'h01;
    idle(3);
    rdp(A_STAT, 32'h81, 8'h00, 8'h00, 1'b1, "t4_stat_p7");
    wr8(A_STAT, 32'h01, 1'b0, "t4_w1c_0");
    rdp(A_STAT, 32'h80, 8'h00, 8'h00, 1'b1, "t4_stat_80");
    wr8(A_STAT, 32'h80, 1'b0, "t4_w1c_7");
    rdp(A_STAT, 32'h00, 8'h00, 8'h00, 1'b0, "t4_stat_clr");

    // T5: event and W1C on the same edge
    gpio_i8 = 8'h00;
    idle(4);
    rd8(A_STAT, 32'h00, 1'b0, "t5_no_fall");
    gpio_i8 = 8'h01;
    idle(1);
    wr8(A_STAT, 32'h01, 1'b0, "t5_w1c_coll");
    rdp(A_STAT, 32'h01, 8'h00, 8'h00, 1'b1, "t5_event_wins");
    wr8(A_STAT, 32'h01, 1'b0, "t5_w1c");
    rdp(A_STAT, 32'h00, 8'h00, 8'h00, 1'b0, "t5_cleared");

    // T6: errors, address aliasing, narrow build
    wr8(A_IN,   32'hFF, 1'b1, "t6_wr_in");
    rd8(A_IN,   32'h01, 1'b0, "t6_in_keep");
    rd8(8'h24,  32'h00, 1'b1, "t6_rd_24");
    wr8(8'h24,  32'hFF, 1'b1, "t6_wr_24");
    wr8(8'h3C,  32'h00, 1'b1, "t6_wr_3c");
    rd8(A_EN,   32'hFF, 1'b0, "t6_en_keep");
    rd8(A_DIR,  32'h00, 1'b0, "t6_dir_keep");
    rd8(8'h43,  32'hFF, 1'b0, "t6_alias_en");
    wr8(8'h05,  32'h03, 1'b0, "t6_alias_dir");
    rdp(A_DIR,  32'h03, 8'h03, 8'h02, 1'b0, "t6_dir_03");
    xfer(1'b1, 1'b1, A_EN, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, "t6_n4_en");
    xfer(1'b1, 1'b0, A_EN, 32'h0, 32'h0000_000F, 1'b0, 1'b1, 8'h0, 8'h0, 1'b0, "t6_n4_en_rd");
    xfer(1'b1, 1'b0, 8'h24, 32'h0, 32'h0, 1'b1, 1'b0, 8'h0, 8'h0, 1'b0, "t6_n4_rd_24");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge PCLK);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
